// File: rtl/forward_controller.sv
// forward_controller: hazard/forwarding control for a 5-stage pipeline with
// separate scalar and vector register files. It keeps a shadow tag pipeline
// alongside the datapath. Each cycle it decides the next-cycle operand
// forwarding and raises a one-cycle stall on a load-use hazard.
module forward_controller #(
  parameter int REGW = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use1,
  input  logic            id_use2,
  input  logic            id_rs1_vec,
  input  logic            id_rs2_vec,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_rd_vec,
  input  logic            id_we,
  input  logic            id_load,
  input  logic            flush,
  output logic            stall,
  output logic            OpAForward,
  output logic            OpBForward,
  output logic            FwdSrcA,
  output logic            FwdSrcB,
  output logic            ex_valid,
  output logic [CNTW-1:0] stall_count
);

  // The load bit is only needed while the producer sits in EX. That is the
  // only place a load-use stall can originate.
  typedef struct packed {
    logic            valid;
    logic            we;
    logic            load;
    logic [REGW-1:0] rd;
    logic            rd_vec;
  } ex_tag_t;

  // The WB-stage producer is never forwarded, because the register file
  // writes before it reads. The pipeline therefore ends at MEM: a WB tag
  // would have no reader.
  typedef struct packed {
    logic            valid;
    logic            we;
    logic [REGW-1:0] rd;
    logic            rd_vec;
  } mem_tag_t;

  ex_tag_t         r_ex_tag;
  mem_tag_t        r_mem_tag;
  ex_tag_t         w_id_tag;
  logic            r_op_a_fwd;
  logic            r_op_b_fwd;
  logic            r_src_a;
  logic            r_src_b;
  logic            r_ex_valid;
  logic [CNTW-1:0] r_stall_cnt;

  logic w_ex_a;
  logic w_ex_b;
  logic w_mem_a;
  logic w_mem_b;
  logic w_load_use;
  logic w_issue;

  // A producer matches a consumer operand when it writes the same register
  // in the same file. Scalar r0 is excluded because it is hardwired to zero.
  function automatic logic src_match(
    input logic            t_valid,
    input logic            t_we,
    input logic [REGW-1:0] t_rd,
    input logic            t_rd_vec,
    input logic            use_b,
    input logic [REGW-1:0] rs,
    input logic            rs_vec
  );
    src_match = t_valid && t_we && use_b && (t_rd == rs) &&
                (t_rd_vec == rs_vec) && (rs_vec || (rs != '0));
  endfunction

  // Operand match against the EX and MEM producers, plus load-use hazard and issue decision
  always_comb begin
    w_ex_a  = src_match(r_ex_tag.valid, r_ex_tag.we, r_ex_tag.rd, r_ex_tag.rd_vec,
                        id_use1, id_rs1, id_rs1_vec);
    w_ex_b  = src_match(r_ex_tag.valid, r_ex_tag.we, r_ex_tag.rd, r_ex_tag.rd_vec,
                        id_use2, id_rs2, id_rs2_vec);
    w_mem_a = src_match(r_mem_tag.valid, r_mem_tag.we, r_mem_tag.rd, r_mem_tag.rd_vec,
                        id_use1, id_rs1, id_rs1_vec);
    w_mem_b = src_match(r_mem_tag.valid, r_mem_tag.we, r_mem_tag.rd, r_mem_tag.rd_vec,
                        id_use2, id_rs2, id_rs2_vec);
    w_load_use = id_valid && r_ex_tag.valid && r_ex_tag.load && (w_ex_a || w_ex_b);
    // flush kills the ID instruction, so the hazard it would have caused is moot
    stall   = w_load_use && !flush;
    w_issue = id_valid && !stall && !flush;
  end

  // Tag entering EX; fields are cleared for a bubble so stale indices never linger
  always_comb begin
    w_id_tag        = '0;
    w_id_tag.valid  = w_issue;
    if (w_issue) begin
      w_id_tag.we     = id_we;
      w_id_tag.load   = id_load;
      w_id_tag.rd     = id_rd;
      w_id_tag.rd_vec = id_rd_vec;
    end
  end

  // Shadow tag pipeline: advances every cycle; a stall inserts a bubble into EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_tag  <= '0;
      r_mem_tag <= '0;
    end else begin
      r_mem_tag.valid  <= r_ex_tag.valid;
      r_mem_tag.we     <= r_ex_tag.we;
      r_mem_tag.rd     <= r_ex_tag.rd;
      r_mem_tag.rd_vec <= r_ex_tag.rd_vec;
      r_ex_tag         <= w_id_tag;
    end
  end

  // Forward controls presented in EX; the newest producer (EX) wins over MEM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_a_fwd <= 1'b0;
      r_op_b_fwd <= 1'b0;
      r_src_a    <= 1'b0;
      r_src_b    <= 1'b0;
      r_ex_valid <= 1'b0;
    end else begin
      r_op_a_fwd <= w_issue && (w_ex_a || w_mem_a);
      r_op_b_fwd <= w_issue && (w_ex_b || w_mem_b);
      r_src_a    <= w_issue && !w_ex_a && w_mem_a;
      r_src_b    <= w_issue && !w_ex_b && w_mem_b;
      r_ex_valid <= w_issue;
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != {CNTW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign OpAForward  = r_op_a_fwd;
  assign OpBForward  = r_op_b_fwd;
  assign FwdSrcA     = r_src_a;
  assign FwdSrcB     = r_src_b;
  assign ex_valid    = r_ex_valid;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_forward_controller.sv
// Testbench for forward_controller. Expected EX-stage outputs are queued when
// each ID instruction is driven, then popped and compared after the clock edge.
module tb_forward_controller;

  localparam int REGW = 4;
  localparam int CNTW = 4;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  typedef struct packed {
    logic ev;
    logic fa;
    logic sa;
    logic fb;
    logic sb;
  } exp_t;

  localparam exp_t E_NONE  = 5'b00000;
  localparam exp_t E_ISS   = 5'b10000;
  localparam exp_t E_A_EX  = 5'b11000;
  localparam exp_t E_A_MEM = 5'b11100;
  localparam exp_t E_B_EX  = 5'b10010;
  localparam exp_t E_B_MEM = 5'b10011;

  logic            clk;
  logic            rst;
  logic            id_valid;
  logic [REGW-1:0] id_rs1;
  logic [REGW-1:0] id_rs2;
  logic            id_use1;
  logic            id_use2;
  logic            id_rs1_vec;
  logic            id_rs2_vec;
  logic [REGW-1:0] id_rd;
  logic            id_rd_vec;
  logic            id_we;
  logic            id_load;
  logic            flush;
  logic            stall;
  logic            OpAForward;
  logic            OpBForward;
  logic            FwdSrcA;
  logic            FwdSrcB;
  logic            ex_valid;
  logic [CNTW-1:0] stall_count;

  exp_t            sb_q[$];
  int              n_pass;
  int              n_total;
  logic [CNTW-1:0] exp_cnt;

  forward_controller #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .id_rs1_vec  (id_rs1_vec),
    .id_rs2_vec  (id_rs2_vec),
    .id_rd       (id_rd),
    .id_rd_vec   (id_rd_vec),
    .id_we       (id_we),
    .id_load     (id_load),
    .flush       (flush),
    .stall       (stall),
    .OpAForward  (OpAForward),
    .OpBForward  (OpBForward),
    .FwdSrcA     (FwdSrcA),
    .FwdSrcB     (FwdSrcB),
    .ex_valid    (ex_valid),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [REGW-1:0] rs1, input logic u1,
                        input logic v1, input logic [REGW-1:0] rs2, input logic u2,
                        input logic v2, input logic [REGW-1:0] rd, input logic rdv,
                        input logic we, input logic ld);
    id_valid = v;   id_rs1 = rs1; id_use1 = u1; id_rs1_vec = v1;
    id_rs2 = rs2;   id_use2 = u2; id_rs2_vec = v2;
    id_rd = rd;     id_rd_vec = rdv; id_we = we; id_load = ld;
  endtask

  task automatic op_idle();
    set_id(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic op_write(input logic [REGW-1:0] rd, input logic rdv, input logic ld);
    set_id(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, rd, rdv, 1'b1, ld);
  endtask

  task automatic op_read_a(input logic [REGW-1:0] rs, input logic vec);
    set_id(1'b1, rs, 1'b1, vec, 4'd0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic op_read_b(input logic [REGW-1:0] rs, input logic vec);
    set_id(1'b1, 4'd0, 1'b0, 1'b0, rs, 1'b1, vec, 4'd9, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic exp_t observed();
    observed = {ex_valid, OpAForward, FwdSrcA, OpBForward, FwdSrcB};
  endfunction

  task automatic test_reset();
    exp_t got;
    rst = 1'b0;
    flush = 1'b0;
    op_write(4'd5, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    got = observed();
    n_total++;
    if (got !== E_NONE) $display("FAIL reset_outputs got=%b exp=%b", got, E_NONE);
    else n_pass++;
    n_total++;
    if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall);
    else n_pass++;
    n_total++;
    if (stall_count !== '0) $display("FAIL reset_count got=%0d exp=0", stall_count);
    else n_pass++;
    op_idle();
    rst = 1'b1;
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_alu_forward();
    exp_t got;
    exp_t exp_v;
    logic exp_stall;
    for (int s = 0; s < 14; s++) begin
      exp_stall = 1'b0;
      case (s)
        0, 4, 8: begin op_write(4'd3, 1'b0, 1'b0); sb_q.push_back(E_ISS); end
        1: begin
          set_id(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0);
          sb_q.push_back(E_A_EX);
        end
        6:  begin op_read_a(4'd3, 1'b0); sb_q.push_back(E_A_MEM); end
        11: begin op_read_a(4'd3, 1'b0); sb_q.push_back(E_ISS); end
        default: begin op_idle(); sb_q.push_back(E_NONE); end
      endcase
      #1;
      n_total++;
      if (stall !== exp_stall) $display("FAIL alu_stall step=%0d got=%b exp=%b", s, stall, exp_stall);
      else n_pass++;
      @(posedge clk);
      #1;
      got = observed();
      exp_v = sb_q.pop_front();
      n_total++;
      if (got !== exp_v) $display("FAIL alu_fwd step=%0d got=%b exp=%b", s, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_load_use();
    exp_t got;
    exp_t exp_v;
    logic exp_stall;
    for (int s = 0; s < 5; s++) begin
      exp_stall = 1'b0;
      case (s)
        0: begin op_write(4'd5, 1'b0, 1'b1); sb_q.push_back(E_ISS); end
        1: begin op_read_b(4'd5, 1'b0); exp_stall = 1'b1; sb_q.push_back(E_NONE); end
        2: begin op_read_b(4'd5, 1'b0); sb_q.push_back(E_B_MEM); end
        default: begin op_idle(); sb_q.push_back(E_NONE); end
      endcase
      #1;
      n_total++;
      if (stall !== exp_stall) $display("FAIL lu_stall step=%0d got=%b exp=%b", s, stall, exp_stall);
      else n_pass++;
      if (exp_stall && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
      @(posedge clk);
      #1;
      got = observed();
      exp_v = sb_q.pop_front();
      n_total++;
      if (got !== exp_v) $display("FAIL lu_fwd step=%0d got=%b exp=%b", s, got, exp_v);
      else n_pass++;
    end
    n_total++;
    if (stall_count !== exp_cnt) $display("FAIL lu_count got=%0d exp=%0d", stall_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_reg_class();
    exp_t got;
    exp_t exp_v;
    for (int s = 0; s < 12; s++) begin
      case (s)
        0: begin op_write(4'd0, 1'b0, 1'b0); sb_q.push_back(E_ISS); end
        1: begin op_read_a(4'd0, 1'b0); sb_q.push_back(E_ISS); end
        4: begin op_write(4'd0, 1'b1, 1'b0); sb_q.push_back(E_ISS); end
        5: begin op_read_a(4'd0, 1'b1); sb_q.push_back(E_A_EX); end
        8: begin op_write(4'd2, 1'b0, 1'b0); sb_q.push_back(E_ISS); end
        9: begin op_read_a(4'd2, 1'b1); sb_q.push_back(E_ISS); end
        default: begin op_idle(); sb_q.push_back(E_NONE); end
      endcase
      @(posedge clk);
      #1;
      got = observed();
      exp_v = sb_q.pop_front();
      n_total++;
      if (got !== exp_v) $display("FAIL regclass step=%0d got=%b exp=%b", s, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_newest_wins();
    exp_t got;
    exp_t exp_v;
    for (int s = 0; s < 10; s++) begin
      case (s)
        0, 1, 5, 6: begin op_write(4'd7, 1'b0, 1'b0); sb_q.push_back(E_ISS); end
        2: begin op_read_a(4'd7, 1'b0); sb_q.push_back(E_A_EX); end
        7: begin op_read_b(4'd7, 1'b0); sb_q.push_back(E_B_EX); end
        default: begin op_idle(); sb_q.push_back(E_NONE); end
      endcase
      @(posedge clk);
      #1;
      got = observed();
      exp_v = sb_q.pop_front();
      n_total++;
      if (got !== exp_v) $display("FAIL newest step=%0d got=%b exp=%b", s, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    exp_t got;
    exp_t exp_v;
    for (int s = 0; s < 4; s++) begin
      flush = 1'b0;
      case (s)
        0: begin op_write(4'd5, 1'b0, 1'b1); sb_q.push_back(E_ISS); end
        1: begin op_read_b(4'd5, 1'b0); flush = 1'b1; sb_q.push_back(E_NONE); end
        default: begin op_idle(); sb_q.push_back(E_NONE); end
      endcase
      #1;
      n_total++;
      if (stall !== 1'b0) $display("FAIL flush_stall step=%0d got=%b exp=0", s, stall);
      else n_pass++;
      @(posedge clk);
      #1;
      got = observed();
      exp_v = sb_q.pop_front();
      n_total++;
      if (got !== exp_v) $display("FAIL flush_fwd step=%0d got=%b exp=%b", s, got, exp_v);
      else n_pass++;
    end
    flush = 1'b0;
    n_total++;
    if (stall_count !== exp_cnt) $display("FAIL flush_count got=%0d exp=%0d", stall_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    exp_t got;
    exp_t exp_v;
    logic exp_stall;
    for (int s = 0; s < 60; s++) begin
      exp_stall = 1'b0;
      case (s % 3)
        0: begin op_write(4'd5, 1'b0, 1'b1); sb_q.push_back(E_ISS); end
        1: begin op_read_b(4'd5, 1'b0); exp_stall = 1'b1; sb_q.push_back(E_NONE); end
        default: begin op_read_b(4'd5, 1'b0); sb_q.push_back(E_B_MEM); end
      endcase
      #1;
      n_total++;
      if (stall !== exp_stall) $display("FAIL sat_stall step=%0d got=%b exp=%b", s, stall, exp_stall);
      else n_pass++;
      if (exp_stall && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
      @(posedge clk);
      #1;
      got = observed();
      exp_v = sb_q.pop_front();
      n_total++;
      if (got !== exp_v) $display("FAIL sat_fwd step=%0d got=%b exp=%b", s, got, exp_v);
      else n_pass++;
      if (s % 3 == 1) begin
        n_total++;
        if (stall_count !== exp_cnt) $display("FAIL sat_count step=%0d got=%0d exp=%0d", s, stall_count, exp_cnt);
        else n_pass++;
      end
    end
    n_total++;
    if (stall_count !== CNT_MAX) $display("FAIL sat_hold got=%0d exp=%0d", stall_count, CNT_MAX);
    else n_pass++;
    op_idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_stall();
    exp_t got;
    op_write(4'd5, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    op_read_b(4'd5, 1'b0);
    #1;
    n_total++;
    if (stall !== 1'b1) $display("FAIL midrst_pre_stall got=%b exp=1", stall);
    else n_pass++;
    rst = 1'b0;
    exp_cnt = '0;
    #1;
    got = observed();
    n_total++;
    if (got !== E_NONE) $display("FAIL midrst_outputs got=%b exp=%b", got, E_NONE);
    else n_pass++;
    n_total++;
    if (stall !== 1'b0) $display("FAIL midrst_stall got=%b exp=0", stall);
    else n_pass++;
    n_total++;
    if (stall_count !== exp_cnt) $display("FAIL midrst_count got=%0d exp=%0d", stall_count, exp_cnt);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_total++;
    if (stall !== 1'b0) $display("FAIL postrst_stall got=%b exp=0", stall);
    else n_pass++;
    sb_q.push_back(E_ISS);
    @(posedge clk);
    #1;
    got = observed();
    n_total++;
    if (got !== sb_q.pop_front()) $display("FAIL postrst_fwd got=%b exp=%b", got, E_ISS);
    else n_pass++;
    n_total++;
    if (stall_count !== exp_cnt) $display("FAIL postrst_count got=%0d exp=%0d", stall_count, exp_cnt);
    else n_pass++;
    op_idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    exp_cnt = '0;
    rst     = 1'b0;
    flush   = 1'b0;
    op_idle();
    test_reset();
    test_alu_forward();
    test_load_use();
    test_reg_class();
    test_newest_wins();
    test_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/forward_controller.md
FORWARD_CONTROLLER -- requirements
Module: forward_controller

Interface
REQ-001 Parameter REGW, default 4, width of register index (16 scalar plus 16 vector registers).
REQ-002 Parameter CNTW, default 16, width of stall performance counter.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 id_valid  in  1  decode-stage instruction valid.
REQ-006 id_rs1, id_rs2  in  REGW  source register indices.
REQ-007 id_use1, id_use2  in  1  instruction reads rs1 / rs2.
REQ-008 id_rs1_vec, id_rs2_vec  in  1  source read from vector file (1) or scalar file (0).
REQ-009 id_rd  in  REGW  destination index; id_rd_vec in 1 vector destination; id_we in 1 writes a register.
REQ-010 id_load  in  1  instruction is a memory load.
REQ-011 flush  in  1  taken branch resolved in EX; kills instruction in ID.
REQ-012 stall  out  1  combinational; hold PC and IF/ID register.
REQ-013 OpAForward, OpBForward  out  1  registered; execute operand A/B takes forwarded path.
REQ-014 FwdSrcA, FwdSrcB  out  1  registered; forwarded path source: 0 = MEM-stage result, 1 = WB-stage result.
REQ-015 ex_valid  out  1  registered; EX-stage instruction valid (0 = bubble).
REQ-016 stall_count  out  CNTW  load-use stall cycles, saturating.

Function
REQ-017 Controller SHALL hold a shadow tag pipeline EX, MEM, WB; each tag = {valid, we, load, rd, rd_vec}.
REQ-018 Every cycle: WB <= MEM, MEM <= EX; EX <= ID tag, or bubble (valid=0) when !id_valid, stall or flush.
REQ-019 Tag match SHALL require: tag valid and we, use bit set, rd == rs, rd_vec == rs_vec, and not (scalar and rd == 0), since scalar r0 is hardwired zero.
REQ-020 Per operand in ID: match with EX tag -> next-cycle Forward=1, FwdSrc=0; else match with MEM tag -> Forward=1, FwdSrc=1; else Forward=0, FwdSrc=0.
REQ-021 EX-tag match SHALL take priority over MEM-tag match (newest producer wins).
REQ-022 stall SHALL be 1 when id_valid, EX tag is a load and either used operand matches it; stall SHALL be exactly one cycle per load-use hazard.
REQ-023 After a stall cycle the load is in MEM; the re-evaluated ID instruction SHALL forward with FwdSrc=1 (WB).
REQ-024 flush SHALL force stall=0 and insert a bubble; flush has priority over stall.
REQ-025 Registered outputs for a bubble SHALL be OpAForward=OpBForward=FwdSrcA=FwdSrcB=ex_valid=0.
REQ-026 The WB-stage producer SHALL NOT be forwarded; the register file is write-before-read.
REQ-027 stall_count SHALL increment on each cycle with stall=1 and saturate at 2^CNTW-1.
REQ-028 Forward latency SHALL be one cycle: decision made in ID, presented during EX.

Reset
REQ-029 When rst=0, all tags SHALL be invalid; OpAForward, OpBForward, FwdSrcA, FwdSrcB, ex_valid, stall_count SHALL be 0 and stall SHALL be 0.
REQ-030 Reset asserted mid-stall SHALL discard the pending hazard; the first cycle after release SHALL show no forwarding.

Verification
REQ-031 add s3 then add s4 using s3 (rs1=3): cycle 2 -> OpAForward=1, FwdSrcA=0, stall=0.
REQ-032 load s5, then add using s5 (rs2=5): stall=1 for one cycle, ex_valid=0 next cycle, then OpBForward=1, FwdSrcB=1, stall_count=1.
REQ-033 Write s0, then read s0: no forwarding. Write v0 then read v0: OpAForward=1. Write s2 then read v2: no forwarding.
REQ-034 Two consecutive writes to s7, then read s7: FwdSrcA=0 (EX producer wins).
REQ-035 Load-use hazard with flush=1 in same cycle -> stall=0, ex_valid=0 next cycle, stall_count unchanged.
REQ-036 stall_count preloaded near 0xFFFF by repeated hazards -> holds at 0xFFFF; rst=0 pulse -> all outputs 0.
